mem_xbar_n: RTL and testbench

Parametrised N-target memory crossbar between the CPU load/store port and its data-side targets (data RAM, MMIO blocks, peripherals). Each request is decoded against a per-target address window, rebased, and forwarded with a grant handshake. One outstanding read is tracked through its response. Unmapped accesses and stalled targets produce an error response instead of undefined data.

---
 rtl/mem_xbar_n.sv | 177 +++++++++++++++++
 tb/tb_mem_xbar_n.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_xbar_n.sv
// N-target data-side crossbar: window decode, rebase, grant handshake, one outstanding read with timeout.
// Optional error statistics (o_err_cnt / o_err_addr) are built when MEM_XBAR_ERRCNT_EN is defined.
module mem_xbar_n #(
    parameter int                    NUM_TGT      = 2,
    parameter logic [NUM_TGT*30-1:0] REGION_START = '0,
    parameter logic [NUM_TGT*30-1:0] REGION_LIMIT = '0,
    parameter logic [15:0]           TIMEOUT      = 16'd255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic [29:0]             i_addr,
    input  logic [31:0]             i_data,
    input  logic                    i_wren,
    input  logic [3:0]              i_mask,
    output logic                    o_gnt,
    output logic                    o_rvalid,
    output logic [31:0]             o_rdata,
    output logic                    o_err,
    output logic [NUM_TGT-1:0]      o_tgt_req,
    output logic [NUM_TGT*30-1:0]   o_tgt_addr,
    output logic [31:0]             o_tgt_data,
    output logic [NUM_TGT-1:0]      o_tgt_wren,
    output logic [3:0]              o_tgt_mask,
    input  logic [NUM_TGT-1:0]      i_tgt_gnt,
    input  logic [NUM_TGT-1:0]      i_tgt_rvalid,
    input  logic [NUM_TGT*32-1:0]   i_tgt_rdata
`ifdef MEM_XBAR_ERRCNT_EN
    ,
    output logic [15:0]             o_err_cnt,
    output logic [29:0]             o_err_addr
`endif
);

    localparam int IDX_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t             state_r;
    logic [IDX_W-1:0]   idx_r;
    logic [15:0]        cnt_r;
    logic [15:0]        cnt_inc_s;
    logic [IDX_W-1:0]   hit_idx_s;
    logic               hit_s;
    logic               match_s;
    logic               rsp_hit_s;
    logic               tmo_s;

    // Address decode; scanning from the top down leaves the lowest matching target selected
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        match_s   = 1'b0;
        for (int k = NUM_TGT - 1; k >= 0; k--) begin
            match_s   = (i_addr >= REGION_START[k*30 +: 30]) && (i_addr < REGION_LIMIT[k*30 +: 30]);
            hit_s     = hit_s | match_s;
            hit_idx_s = match_s ? IDX_W'(k) : hit_idx_s;
        end
    end

    // Rebased address toward every target, modulo 2^30
    always_comb begin
        o_tgt_addr = '0;
        for (int k = 0; k < NUM_TGT; k++) begin
            o_tgt_addr[k*30 +: 30] = i_addr - REGION_START[k*30 +: 30];
        end
    end

    assign o_tgt_data = i_data;
    assign o_tgt_mask = i_mask;
    assign cnt_inc_s  = cnt_r + 16'd1;
    assign rsp_hit_s  = (state_r == ST_RESP) && i_tgt_rvalid[idx_r];
    // A response arriving in the expiry cycle takes priority over the timeout
    assign tmo_s      = (state_r == ST_RESP) && !rsp_hit_s &&
                        (TIMEOUT != 16'd0) && (cnt_inc_s == TIMEOUT);

    // Request routing and response muxing
    always_comb begin
        o_tgt_req  = '0;
        o_tgt_wren = '0;
        o_gnt      = 1'b0;
        o_rvalid   = 1'b0;
        o_err      = 1'b0;
        o_rdata    = 32'd0;
        case (state_r)
            ST_IDLE: begin
                if (hit_s) begin
                    o_tgt_req[hit_idx_s]  = i_req;
                    o_tgt_wren[hit_idx_s] = i_req & i_wren;
                    o_gnt                 = i_req & i_tgt_gnt[hit_idx_s];
                end else begin
                    o_gnt = i_req;
                end
            end
            ST_RESP: begin
                if (rsp_hit_s) begin
                    o_rvalid = 1'b1;
                    o_rdata  = i_tgt_rdata[idx_r*32 +: 32];
                end else if (tmo_s) begin
                    o_rvalid = 1'b1;
                    o_err    = 1'b1;
                end else begin
                    o_rvalid = 1'b0;
                end
            end
            ST_ERR: begin
                o_rvalid = 1'b1;
                o_err    = 1'b1;
            end
            default: begin
                o_rvalid = 1'b0;
            end
        endcase
    end

    // Transaction state machine: latched target index and response timeout counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            cnt_r   <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (o_gnt && !hit_s) begin
                        state_r <= ST_ERR;
                    end else if (o_gnt && !i_wren) begin
                        state_r <= ST_RESP;
                        idx_r   <= hit_idx_s;
                        cnt_r   <= 16'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    if (rsp_hit_s || tmo_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                ST_ERR: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_XBAR_ERRCNT_EN
    logic [29:0] req_addr_r;

    // Error statistics: address captured at grant, reported when that access errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr_r <= 30'd0;
            o_err_cnt  <= 16'd0;
            o_err_addr <= 30'd0;
        end else begin
            if (o_gnt) begin
                req_addr_r <= i_addr;
            end
            if (o_rvalid && o_err) begin
                o_err_cnt  <= (o_err_cnt == 16'hFFFF) ? o_err_cnt : o_err_cnt + 16'd1;
                o_err_addr <= req_addr_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_xbar_n.sv
// Self-checking bench for mem_xbar_n: RAM [0x000,0x400) and MMIO [0x400,0x410), TIMEOUT 4.
// Directed scenarios followed by randomized transactions against a window-level reference model.
module tb_mem_xbar_n;

    localparam int NT  = 2;
    localparam int TMO = 4;

    int starts [NT] = '{32'h000, 32'h400};
    int limits [NT] = '{32'h400, 32'h410};

    logic              clk;
    logic              rst;
    logic              i_req;
    logic [29:0]       i_addr;
    logic [31:0]       i_data;
    logic              i_wren;
    logic [3:0]        i_mask;
    logic              o_gnt;
    logic              o_rvalid;
    logic [31:0]       o_rdata;
    logic              o_err;
    logic [NT-1:0]     o_tgt_req;
    logic [NT*30-1:0]  o_tgt_addr;
    logic [31:0]       o_tgt_data;
    logic [NT-1:0]     o_tgt_wren;
    logic [3:0]        o_tgt_mask;
    logic [NT-1:0]     i_tgt_gnt;
    logic [NT-1:0]     i_tgt_rvalid;
    logic [NT*32-1:0]  i_tgt_rdata;
`ifdef MEM_XBAR_ERRCNT_EN
    logic [15:0]       o_err_cnt;
    logic [29:0]       o_err_addr;
`endif

    int          n_pass  = 0;
    int          n_total = 0;
    int          n_err   = 0;
    logic [29:0] e_addr  = 30'd0;

    mem_xbar_n #(
        .NUM_TGT      (NT),
        .REGION_START ({30'h400, 30'h000}),
        .REGION_LIMIT ({30'h410, 30'h400}),
        .TIMEOUT      (16'd4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_data       (i_data),
        .i_wren       (i_wren),
        .i_mask       (i_mask),
        .o_gnt        (o_gnt),
        .o_rvalid     (o_rvalid),
        .o_rdata      (o_rdata),
        .o_err        (o_err),
        .o_tgt_req    (o_tgt_req),
        .o_tgt_addr   (o_tgt_addr),
        .o_tgt_data   (o_tgt_data),
        .o_tgt_wren   (o_tgt_wren),
        .o_tgt_mask   (o_tgt_mask),
        .i_tgt_gnt    (i_tgt_gnt),
        .i_tgt_rvalid (i_tgt_rvalid),
        .i_tgt_rdata  (i_tgt_rdata)
`ifdef MEM_XBAR_ERRCNT_EN
        ,
        .o_err_cnt    (o_err_cnt),
        .o_err_addr   (o_err_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int dec(input logic [29:0] a);
        for (int k = 0; k < NT; k++) begin
            if (32'(a) >= starts[k] && 32'(a) < limits[k]) return k;
        end
        return -1;
    endfunction

    task automatic chk_stats();
`ifdef MEM_XBAR_ERRCNT_EN
        chk("err_cnt", 64'(o_err_cnt), 64'(n_err));
        chk("err_addr", 64'(o_err_addr), 64'(e_addr));
`endif
    endtask

    // Called just after a rising edge; leaves the bench just after a rising edge.
    task automatic xact(input logic [29:0] a, input logic wr, input logic [3:0] m,
                        input int gdly, input int lat);
        int          k;
        int          resp_at;
        logic        exp_err;
        logic [NT-1:0] oh;
        logic [31:0] wd;
        logic [31:0] rd;
        k  = dec(a);
        wd = $urandom;
        rd = $urandom;
        i_req = 1'b1; i_addr = a; i_wren = wr; i_data = wd; i_mask = m;
        if (k >= 0) begin
            oh = 2'b01 << k;
            for (int c = 0; c < gdly; c++) begin
                i_tgt_gnt = 2'b00;
                #3;
                chk("stall_gnt", 64'(o_gnt), 64'd0);
                chk("stall_req", 64'(o_tgt_req), 64'(oh));
                @(posedge clk); #1;
            end
            i_tgt_gnt = oh;
            #3;
            chk("gnt", 64'(o_gnt), 64'd1);
            chk("tgt_req", 64'(o_tgt_req), 64'(oh));
            chk("tgt_wren", 64'(o_tgt_wren), wr ? 64'(oh) : 64'd0);
            chk("tgt_addr", 64'(o_tgt_addr[k*30 +: 30]), 64'(30'(32'(a) - starts[k])));
            chk("tgt_data", 64'(o_tgt_data), 64'(wd));
            chk("tgt_mask", 64'(o_tgt_mask), 64'(m));
            @(posedge clk); #1;
            if (wr) begin
                i_req = 1'b0; i_tgt_gnt = 2'b00;
                #3;
                chk("wr_no_rsp", 64'(o_rvalid), 64'd0);
                @(posedge clk); #1;
            end else begin
                resp_at = (lat <= TMO) ? lat : TMO;
                exp_err = (lat > TMO);
                for (int c = 1; c <= resp_at; c++) begin
                    i_req        = 1'($urandom_range(0, 1));
                    i_tgt_gnt    = 2'b11;
                    i_tgt_rvalid = ((c == lat) ? oh : 2'b00) | (($urandom_range(0, 1) == 1) ? ~oh : 2'b00);
                    i_tgt_rdata  = {$urandom, $urandom};
                    i_tgt_rdata[k*32 +: 32] = rd;
                    #3;
                    chk("busy_gnt", 64'(o_gnt), 64'd0);
                    chk("busy_req", 64'(o_tgt_req), 64'd0);
                    if (c < resp_at) begin
                        chk("rsp_wait", 64'(o_rvalid), 64'd0);
                    end else begin
                        chk("rsp_valid", 64'(o_rvalid), 64'd1);
                        chk("rsp_err", 64'(o_err), 64'(exp_err));
                        chk("rsp_data", 64'(o_rdata), exp_err ? 64'd0 : 64'(rd));
                    end
                    @(posedge clk); #1;
                end
                i_req = 1'b0; i_tgt_gnt = 2'b00;
                i_tgt_rvalid = oh;
                #3;
                chk("late_rvalid", 64'(o_rvalid), 64'd0);
                @(posedge clk); #1;
                if (exp_err) begin
                    n_err++;
                    e_addr = a;
                end
            end
        end else begin
            i_tgt_gnt = 2'b11;
            #3;
            chk("unmap_gnt", 64'(o_gnt), 64'd1);
            chk("unmap_req", 64'(o_tgt_req), 64'd0);
            @(posedge clk); #1;
            i_req = 1'($urandom_range(0, 1));
            i_tgt_rvalid = 2'($urandom_range(0, 3));
            #3;
            chk("unmap_rvalid", 64'(o_rvalid), 64'd1);
            chk("unmap_err", 64'(o_err), 64'd1);
            chk("unmap_rdata", 64'(o_rdata), 64'd0);
            chk("unmap_busy_gnt", 64'(o_gnt), 64'd0);
            @(posedge clk); #1;
            n_err++;
            e_addr = a;
        end
        i_req = 1'b0; i_tgt_gnt = 2'b00; i_tgt_rvalid = 2'b00;
        chk_stats();
    endtask

    initial begin
        logic [29:0] ra;
        rst = 1'b1;
        i_req = 1'b0; i_addr = 30'd0; i_data = 32'd0; i_wren = 1'b0; i_mask = 4'd0;
        i_tgt_gnt = 2'b00; i_tgt_rvalid = 2'b00; i_tgt_rdata = 64'd0;
        #3;
        chk("rst_gnt", 64'(o_gnt), 64'd0);
        chk("rst_rvalid", 64'(o_rvalid), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_rdata", 64'(o_rdata), 64'd0);
        chk("rst_tgt_req", 64'(o_tgt_req), 64'd0);
        chk("rst_tgt_wren", 64'(o_tgt_wren), 64'd0);
        chk_stats();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        xact(30'h004, 1'b0, 4'hF, 0, 1);
        xact(30'h402, 1'b1, 4'b0011, 0, 0);
        xact(30'h500, 1'b0, 4'hF, 0, 0);
        xact(30'h010, 1'b0, 4'hF, 0, 5);
        xact(30'h405, 1'b0, 4'hF, 3, 1);
        xact(30'h100, 1'b0, 4'hF, 0, 4);
        xact(30'h40F, 1'b0, 4'hF, 1, 2);
        xact(30'h410, 1'b1, 4'hA, 0, 0);
        xact(30'h3FF, 1'b0, 4'hF, 0, 3);

        // Reset while a read is outstanding
        i_req = 1'b1; i_addr = 30'h020; i_wren = 1'b0; i_tgt_gnt = 2'b01;
        #3;
        chk("pre_rst_gnt", 64'(o_gnt), 64'd1);
        @(posedge clk); #1;
        i_req = 1'b0; i_tgt_gnt = 2'b00;
        #3;
        chk("pre_rst_wait", 64'(o_rvalid), 64'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", 64'(o_gnt), 64'd0);
        chk("mid_rst_rvalid", 64'(o_rvalid), 64'd0);
        chk("mid_rst_err", 64'(o_err), 64'd0);
        chk("mid_rst_rdata", 64'(o_rdata), 64'd0);
        chk("mid_rst_req", 64'(o_tgt_req), 64'd0);
        n_err = 0;
        e_addr = 30'd0;
        chk_stats();
        @(posedge clk); #1;
        rst = 1'b0;
        i_tgt_rvalid = 2'b01;
        i_tgt_rdata  = {$urandom, $urandom};
        #3;
        chk("stale_rvalid", 64'(o_rvalid), 64'd0);
        chk("stale_rdata", 64'(o_rdata), 64'd0);
        @(posedge clk); #1;
        i_tgt_rvalid = 2'b00;

        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 5))
                0:       ra = 30'($urandom_range(0, 32'h3FF));
                1:       ra = 30'($urandom_range(32'h400, 32'h40F));
                2:       ra = 30'h3FF;
                3:       ra = 30'h400;
                4:       ra = 30'h40F;
                default: ra = 30'(32'h410 + $urandom_range(0, 32'hFFFF));
            endcase
            xact(ra, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 2), $urandom_range(1, 6));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
